// File: rtl/mem_arb.sv
// rtl/mem_arb.sv - fixed-priority arbiter of fetch and data ports onto one single-outstanding memory bus
module mem_arb #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_rd,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic [DATA_W-1:0]   i_data,
  output logic                b_rd_i,
  input  logic                d_rd,
  input  logic                d_wr,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_be,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                b_rd,
  output logic                b_wr,
  output logic                m_rd,
  output logic                m_wr,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_be,
  input  logic [DATA_W-1:0]   m_rdata,
  input  logic                m_ack
);

  typedef enum logic [1:0] {IDLE, BUS_I, BUS_D} state_t;

  state_t state, state_nxt;

  logic              i_vld, dr_vld, dw_vld;
  logic [ADDR_W-1:0] i_addr_q, dr_addr_q, dw_addr_q;
  logic              i_hit, dr_hit, dw_hit;
  logic              i_pend, d_pend;
  logic              issue_i, issue_d;
  logic              ack_i, ack_dr, ack_dw;

  // A served flag only counts while the requester still points at the same address
  assign i_hit  = i_vld  && (i_addr == i_addr_q);
  assign dr_hit = dr_vld && (d_addr == dr_addr_q);
  assign dw_hit = dw_vld && (d_addr == dw_addr_q);

  assign b_rd_i = i_rd && !i_hit;
  assign b_wr   = d_wr && !dw_hit;
  assign b_rd   = d_wr ? b_wr : (d_rd && !dr_hit);

  assign i_pend = b_rd_i;
  assign d_pend = b_rd || b_wr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (d_pend)      state_nxt = BUS_D;
        else if (i_pend) state_nxt = BUS_I;
      end
      BUS_I, BUS_D: begin
        if (m_ack) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // m_wr doubles as the read/write tag of the data transaction until its ack
  always_comb begin
    issue_i = 1'b0;
    issue_d = 1'b0;
    ack_i   = 1'b0;
    ack_dr  = 1'b0;
    ack_dw  = 1'b0;
    case (state)
      IDLE: begin
        issue_d = d_pend;
        issue_i = !d_pend && i_pend;
      end
      BUS_I: ack_i = m_ack;
      BUS_D: begin
        ack_dr = m_ack && !m_wr;
        ack_dw = m_ack && m_wr;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_rd    <= 1'b0;
      m_wr    <= 1'b0;
      m_addr  <= '0;
      m_wdata <= '0;
      m_be    <= '0;
    end else if (issue_d) begin
      m_rd    <= !d_wr;
      m_wr    <= d_wr;
      m_addr  <= d_addr;
      m_wdata <= d_wdata;
      m_be    <= d_wr ? d_be : '1;
    end else if (issue_i) begin
      m_rd    <= 1'b1;
      m_wr    <= 1'b0;
      m_addr  <= i_addr;
      m_be    <= '1;
    end else if (ack_i || ack_dr || ack_dw) begin
      m_rd    <= 1'b0;
      m_wr    <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_data  <= '0;
      d_rdata <= '0;
    end else begin
      if (ack_i)  i_data  <= m_rdata;
      if (ack_dr) d_rdata <= m_rdata;
    end
  end

  // m_addr holds the issue address, so it is the address the served flag latches
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_vld     <= 1'b0;
      dr_vld    <= 1'b0;
      dw_vld    <= 1'b0;
      i_addr_q  <= '0;
      dr_addr_q <= '0;
      dw_addr_q <= '0;
    end else begin
      if (ack_i) begin
        i_vld    <= 1'b1;
        i_addr_q <= m_addr;
      end else if (!i_rd || i_addr != i_addr_q) begin
        i_vld    <= 1'b0;
      end
      if (ack_dr) begin
        dr_vld    <= 1'b1;
        dr_addr_q <= m_addr;
      end else if (!d_rd || d_addr != dr_addr_q) begin
        dr_vld    <= 1'b0;
      end
      if (ack_dw) begin
        dw_vld    <= 1'b1;
        dw_addr_q <= m_addr;
      end else if (!d_wr || d_addr != dw_addr_q) begin
        dw_vld    <= 1'b0;
      end
    end
  end

endmodule
